// File: rtl/receiver_framed_pkg.sv
// Shared types and constants for the framed serial receiver.
// FSM state encoding, parity-mode codes and the bit positions of fields in a FIFO entry.
package receiver_framed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PUSH  = 2'd2
  } rx_state_t;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_ODD   = 2'b10;
  localparam logic [1:0] PAR_NONE3 = 2'b11;

  // FIFO entry layout: {frame, ferr, perr}
  localparam int FE_PERR = 0;
  localparam int FE_FERR = 1;
  localparam int FE_DATA = 2;

endpackage

// File: rtl/receiver_framed_fifo.sv
// Frame FIFO: power-of-two depth, wrapping pointers, occupancy counter with DEPTH+1 states.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module receiver_framed_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CW'(DEPTH));
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~full_o | w_pop);
  assign dout_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/receiver_framed.sv
// Framed serial receiver: start detect, variable-length framing, stop/parity checks, frame FIFO.
// Parity checking and the par_mode_i port exist only when SERIAL_RX_PARITY_EN is defined.
// States: IDLE wait for start | SHIFT sample frame bits | PUSH enqueue frame, one cycle
module receiver_framed
  import receiver_framed_pkg::*;
#(
  parameter int SHIFT_REG_WIDTH = 64,
  parameter int BAUD_RATE_WIDTH = 32,
  parameter int BITS_WIDTH      = 7,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [BITS_WIDTH-1:0]      bits_i,
  input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
  input  logic                       ext_clk_i,
  input  logic                       rxd_i,
  input  logic                       rxc_i,
`ifdef SERIAL_RX_PARITY_EN
  input  logic [1:0]                 par_mode_i,
`endif
  output logic [SHIFT_REG_WIDTH-1:0] dat_o,
  output logic                       ferr_o,
  output logic                       perr_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       overrun_o,
  input  logic                       ovr_clr_i,
  output logic                       idle_o
);

  localparam logic [BITS_WIDTH-1:0] LP_W = BITS_WIDTH'(SHIFT_REG_WIDTH);

  rx_state_t                    r_state, w_next;
  logic                         r_rxd_m, r_rxd_s, r_rxd_d;
  logic                         r_rxc_m, r_rxc_s, r_rxc_d;
  logic [BAUD_RATE_WIDTH-1:0]   r_baud;
  logic [SHIFT_REG_WIDTH-1:0]   r_sr;
  logic [BITS_WIDTH-1:0]        r_cnt, r_bits, w_bits_clamp, w_sh;
  logic                         r_ovr;
  logic                         w_strobe, w_int_start, w_ext_start, w_false, w_last;
  logic                         w_push_req, w_pop, w_full, w_empty, w_ferr, w_perr;
  logic [SHIFT_REG_WIDTH-1:0]   w_sr_shifted, w_frame;
  logic [SHIFT_REG_WIDTH+1:0]   w_fifo_din, w_fifo_dout;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      {r_rxd_m, r_rxd_s, r_rxd_d} <= 3'b111;
      {r_rxc_m, r_rxc_s, r_rxc_d} <= 3'b000;
    end else begin
      {r_rxd_m, r_rxd_s, r_rxd_d} <= {rxd_i, r_rxd_m, r_rxd_s};
      {r_rxc_m, r_rxc_s, r_rxc_d} <= {rxc_i, r_rxc_m, r_rxc_s};
    end
  end

  assign w_strobe     = ext_clk_i ? (r_rxc_s & ~r_rxc_d) : (r_baud == '0);
  assign w_int_start  = (r_state == ST_IDLE) & ~ext_clk_i & r_rxd_d & ~r_rxd_s;
  assign w_ext_start  = (r_state == ST_IDLE) & ext_clk_i & w_strobe & ~r_rxd_s;
  assign w_false      = (r_state == ST_SHIFT) & w_strobe & (r_cnt == '0) & r_rxd_s;
  assign w_last       = (r_state == ST_SHIFT) & w_strobe & ~w_false &
                        ((r_cnt + BITS_WIDTH'(1)) == r_bits);
  assign w_sr_shifted = {r_rxd_s, r_sr[SHIFT_REG_WIDTH-1:1]};
  assign w_bits_clamp = (bits_i < BITS_WIDTH'(2)) ? BITS_WIDTH'(2) :
                        (bits_i > LP_W) ? LP_W : bits_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_int_start || w_ext_start) w_next = ST_SHIFT;
      ST_SHIFT: if (w_false) w_next = ST_IDLE;
                else if (w_last) w_next = ST_PUSH;
      ST_PUSH:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    idle_o     = (r_state == ST_IDLE);
    w_push_req = (r_state == ST_PUSH);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_baud <= '0;
      r_sr   <= '1;
      r_cnt  <= '0;
      r_bits <= BITS_WIDTH'(2);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_int_start) begin
            r_baud <= baud_i >> 1;
            r_cnt  <= '0;
            r_bits <= w_bits_clamp;
          end else if (w_ext_start) begin
            r_sr   <= w_sr_shifted;
            r_cnt  <= BITS_WIDTH'(1);
            r_bits <= w_bits_clamp;
          end
        end
        ST_SHIFT: begin
          if (!ext_clk_i) r_baud <= (r_baud == '0) ? baud_i : r_baud - BAUD_RATE_WIDTH'(1);
          if (w_false) begin
            r_sr <= '1;
          end else if (w_strobe) begin
            r_sr  <= w_sr_shifted;
            r_cnt <= r_cnt + BITS_WIDTH'(1);
          end
        end
        ST_PUSH: r_sr <= '1;
        default: r_sr <= '1;
      endcase
    end
  end

  // The stop bit is the last one shifted in, so it always sits at the shift register MSB.
  assign w_sh    = LP_W - r_bits;
  assign w_frame = r_sr >> w_sh;
  assign w_ferr  = ~r_sr[SHIFT_REG_WIDTH-1];

`ifdef SERIAL_RX_PARITY_EN
  logic [1:0] r_par;
  logic       w_par_x;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_par <= PAR_NONE;
    else if (w_int_start || w_ext_start) r_par <= par_mode_i;
  end

  // XOR over data+parity: whole frame minus the start and stop bits.
  assign w_par_x = ^w_frame ^ w_frame[0] ^ r_sr[SHIFT_REG_WIDTH-1];
  assign w_perr  = (r_par == PAR_EVEN) ? w_par_x :
                   (r_par == PAR_ODD)  ? ~w_par_x : 1'b0;
`else
  assign w_perr  = 1'b0;
`endif

  assign w_pop      = ~w_empty & ready_i;
  assign w_fifo_din = {w_frame, w_ferr, w_perr};

  receiver_framed_fifo #(
    .WIDTH(SHIFT_REG_WIDTH + 2),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push_i (w_push_req),
    .pop_i  (w_pop),
    .din_i  (w_fifo_din),
    .dout_o (w_fifo_dout),
    .full_o (w_full),
    .empty_o(w_empty)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) r_ovr <= 1'b0;
    else if (w_push_req && w_full && !w_pop) r_ovr <= 1'b1;
    else if (ovr_clr_i) r_ovr <= 1'b0;
  end

  assign valid_o   = ~w_empty;
  assign dat_o     = valid_o ? w_fifo_dout[SHIFT_REG_WIDTH+1:FE_DATA] : '0;
  assign ferr_o    = valid_o & w_fifo_dout[FE_FERR];
  assign perr_o    = valid_o & w_fifo_dout[FE_PERR];
  assign overrun_o = r_ovr;

endmodule

// File: tb/tb_receiver_framed.sv
// Bench for receiver_framed: vector table, hand-written corner sequences and random frames
// checked against a line-level model of what each received frame must look like.
module tb_receiver_framed;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [6:0]  bits_i = 7'd10;
  logic [31:0] baud_i = 32'd49;
  logic        ext_clk_i = 1'b0;
  logic        rxd_i = 1'b1;
  logic        rxc_i = 1'b0;
  logic        ready_i = 1'b0;
  logic        ovr_clr_i = 1'b0;
  logic [63:0] dat_o;
  logic        ferr_o, perr_o, valid_o, overrun_o, idle_o;
`ifdef SERIAL_RX_PARITY_EN
  logic [1:0]  par_mode_i = 2'b00;
`endif

  int checks = 0;
  int errors = 0;

  receiver_framed dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .bits_i   (bits_i),
    .baud_i   (baud_i),
    .ext_clk_i(ext_clk_i),
    .rxd_i    (rxd_i),
    .rxc_i    (rxc_i),
`ifdef SERIAL_RX_PARITY_EN
    .par_mode_i(par_mode_i),
`endif
    .dat_o    (dat_o),
    .ferr_o   (ferr_o),
    .perr_o   (perr_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .overrun_o(overrun_o),
    .ovr_clr_i(ovr_clr_i),
    .idle_o   (idle_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] line;
    int          nb;
    logic [6:0]  bits;
    int          baud;
    logic [63:0] exp_dat;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_line(input logic [63:0] line, input int nb, input int baud);
    for (int i = 0; i < nb; i++) begin
      rxd_i = line[i];
      repeat (baud + 1) @(negedge clk_i);
    end
    rxd_i = 1'b1;
    repeat (2 * (baud + 1) + 4) @(negedge clk_i);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid_o && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    chk(name, 64'(valid_o), 64'd1);
  endtask

  task automatic pop_one();
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [63:0] exp_dat,
                             input logic exp_ferr, input logic exp_perr);
    wait_valid({name, "_valid"});
    chk({name, "_dat"}, dat_o, exp_dat);
    chk({name, "_ferr"}, 64'(ferr_o), 64'(exp_ferr));
    chk({name, "_perr"}, 64'(perr_o), 64'(exp_perr));
    pop_one();
  endtask

  initial begin
    logic [63:0] q_exp[$];
    logic [63:0] line, mask, exp_d;
    int nb, bd, n;

    vecs[0] = '{64'h34A, 10, 7'd10, 49, 64'h34A, 1'b0};
    vecs[1] = '{64'h14A, 10, 7'd10, 9, 64'h14A, 1'b1};
    vecs[2] = '{64'h2, 2, 7'd0, 5, 64'h2, 1'b0};
    vecs[3] = '{64'h0, 2, 7'd1, 5, 64'h0, 1'b1};
    vecs[4] = '{64'h74A, 11, 7'd11, 7, 64'h74A, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_1234, 64, 7'd100, 3, 64'h8000_0000_0000_1234, 1'b0};
    vecs[6] = '{64'h4000_0000_0000_0010, 64, 7'd64, 3, 64'h4000_0000_0000_0010, 1'b1};
    vecs[7] = '{64'h1FE, 9, 7'd9, 4, 64'h1FE, 1'b0};

    repeat (3) @(negedge clk_i);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_dat", dat_o, 64'd0);
    chk("rst_ferr", 64'(ferr_o), 64'd0);
    chk("rst_perr", 64'(perr_o), 64'd0);
    chk("rst_ovr", 64'(overrun_o), 64'd0);
    chk("rst_idle", 64'(idle_o), 64'd1);
    reset_i = 1'b0;
    repeat (3) @(negedge clk_i);

    for (int v = 0; v < 8; v++) begin
      bits_i = vecs[v].bits;
      baud_i = 32'(vecs[v].baud);
      send_line(vecs[v].line, vecs[v].nb, vecs[v].baud);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_dat, vecs[v].exp_ferr, 1'b0);
      chk($sformatf("vec%0d_idle", v), 64'(idle_o), 64'd1);
      chk($sformatf("vec%0d_empty", v), 64'(valid_o), 64'd0);
    end

    // Short low glitch at baud 49: the mid-bit sample sees high again.
    bits_i = 7'd10; baud_i = 32'd49;
    rxd_i = 1'b0;
    repeat (10) @(negedge clk_i);
    rxd_i = 1'b1;
    chk("glitch_busy", 64'(idle_o), 64'd0);
    repeat (100) @(negedge clk_i);
    chk("glitch_idle", 64'(idle_o), 64'd1);
    chk("glitch_novalid", 64'(valid_o), 64'd0);

    // Overrun: five frames into four slots with the consumer stalled.
    baud_i = 32'd3;
    for (int k = 0; k < 5; k++) begin
      line = 64'h200 | (64'((8'h11 * (k + 1)) & 8'hFF) << 1);
      if (k < 4) q_exp.push_back(line);
      send_line(line, 10, 3);
      if (k == 3) chk("ovr_before", 64'(overrun_o), 64'd0);
    end
    repeat (5) @(negedge clk_i);
    chk("ovr_set", 64'(overrun_o), 64'd1);
    ovr_clr_i = 1'b1;
    @(negedge clk_i);
    ovr_clr_i = 1'b0;
    chk("ovr_clr", 64'(overrun_o), 64'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovr_q%0d_valid", k), 64'(valid_o), 64'd1);
      exp_d = q_exp.pop_front();
      chk($sformatf("ovr_q%0d_dat", k), dat_o, exp_d);
      pop_one();
    end
    chk("ovr_drained", 64'(valid_o), 64'd0);

    // External bit clock, 11 zero bits.
    ext_clk_i = 1'b1;
    bits_i = 7'd11;
    rxd_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("ext_idle_pre", 64'(idle_o), 64'd1);
    for (int p = 1; p <= 11; p++) begin
      rxc_i = 1'b1;
      repeat (3) @(negedge clk_i);
      rxc_i = 1'b0;
      repeat (3) @(negedge clk_i);
      if (p == 1 || p == 10) chk($sformatf("ext_busy_p%0d", p), 64'(idle_o), 64'd0);
    end
    chk("ext_idle_post", 64'(idle_o), 64'd1);
    check_frame("ext", 64'h0, 1'b1, 1'b0);
    rxd_i = 1'b1;
    repeat (4) @(negedge clk_i);
    ext_clk_i = 1'b0;

    // Reset in the middle of a frame, then a clean frame.
    bits_i = 7'd10; baud_i = 32'd9;
    for (int i = 0; i < 4; i++) begin
      rxd_i = vecs[0].line[i];
      repeat (10) @(negedge clk_i);
    end
    rxd_i = 1'b1;
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    repeat (30) @(negedge clk_i);
    chk("midrst_idle", 64'(idle_o), 64'd1);
    chk("midrst_novalid", 64'(valid_o), 64'd0);
    send_line(64'h3E0, 10, 9);
    check_frame("midrst_next", 64'h3E0, 1'b0, 1'b0);

`ifdef SERIAL_RX_PARITY_EN
    par_mode_i = 2'b10;
    bits_i = 7'd11; baud_i = 32'd5;
    send_line(64'h74A, 11, 5);
    check_frame("par_odd_ok", 64'h74A, 1'b0, 1'b0);
    send_line(64'h54A, 11, 5);
    check_frame("par_odd_bad", 64'h54A, 1'b0, 1'b1);
    par_mode_i = 2'b01;
    send_line(64'h54A, 11, 5);
    check_frame("par_even_ok", 64'h54A, 1'b0, 1'b0);
    par_mode_i = 2'b00;
`endif

    // Random frames: the expected frame is the line bits themselves, masked to the length.
    for (int r = 0; r < 20; r++) begin
      nb = int'($urandom_range(20, 2));
      bd = int'($urandom_range(7, 2));
      mask = (64'd1 << nb) - 64'd1;
      line = {$urandom, $urandom} & mask & ~64'd1;
      if ($urandom_range(3, 0) != 0) line = line | (64'd1 << (nb - 1));
      bits_i = 7'(nb);
      baud_i = 32'(bd);
      send_line(line, nb, bd);
      n = 0;
      while (!valid_o && n < 400) begin
        @(negedge clk_i);
        n++;
      end
      chk($sformatf("rnd%0d_valid", r), 64'(valid_o), 64'd1);
      chk($sformatf("rnd%0d_dat", r), dat_o, line & mask);
      chk($sformatf("rnd%0d_ferr", r), 64'(ferr_o), 64'(!line[nb-1]));
      chk($sformatf("rnd%0d_perr", r), 64'(perr_o), 64'd0);
      pop_one();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
